// File: rtl/inst_sram_like_slave.sv
// Instruction-port memory responder on the sram-like protocol: byte-strobed
// writes, in-order read/write responses after a fixed programmable latency.
module inst_sram_like_slave #(
  parameter int ADDR_W    = 12,
  parameter int LATENCY   = 1,
  parameter int QDEPTH    = 2,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [2:0] QDEPTH_C  = 3'(QDEPTH);
  localparam logic [1:0] QDEPTH_M1 = 2'(QDEPTH - 1);
  localparam logic [2:0] AGE_MAX   = 3'(LATENCY - 1);
  localparam logic [2:0] AGE_START = (LATENCY > 1) ? 3'd1 : 3'd0;
  // With a single cycle of latency the response is registered at the accepting
  // edge itself, so nothing is ever parked in the queue.
  localparam bit         BYPASS    = (LATENCY == 1);

  logic [31:0] mem [DEPTH];

  logic              resetn_q;
  logic [2:0]        count_reg, count_next;
  logic [1:0]        head_reg, tail_reg;
  logic [31:0]       q_rdata [4];
  logic [2:0]        q_age   [4];
  logic [ADDR_W-1:0] word_idx;
  logic              accept, enq, retire;
  logic              data_ok_reg;
  logic [31:0]       rdata_reg;
  logic              unused_inputs;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == QDEPTH_M1) ? 2'd0 : p + 2'd1;
  endfunction

  assign word_idx      = inst_sram_addr[ADDR_W+1:2];
  assign unused_inputs = ^{inst_sram_size, inst_sram_addr[1:0], inst_sram_addr[31:ADDR_W+2]};

  // No bypass from a retiring entry: acceptance only looks at the registered count.
  assign inst_sram_addr_ok = resetn && resetn_q && (count_reg < QDEPTH_C);
  assign accept            = inst_sram_req && inst_sram_addr_ok;
  assign enq               = accept && !BYPASS;
  assign retire            = !BYPASS && (count_reg != 3'd0) && (q_age[head_reg] == AGE_MAX);

  always_comb begin
    count_next = count_reg;
    if (enq && !retire) begin
      count_next = count_reg + 3'd1;
    end else if (!enq && retire) begin
      count_next = count_reg - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      resetn_q    <= 1'b0;
      count_reg   <= 3'd0;
      head_reg    <= 2'd0;
      tail_reg    <= 2'd0;
      data_ok_reg <= 1'b0;
      rdata_reg   <= 32'd0;
    end else begin
      resetn_q  <= 1'b1;
      count_reg <= count_next;
      if (enq) begin
        tail_reg <= ptr_inc(tail_reg);
      end
      if (retire) begin
        head_reg <= ptr_inc(head_reg);
      end
      if (BYPASS) begin
        data_ok_reg <= accept;
        if (accept) begin
          rdata_reg <= inst_sram_wr ? 32'd0 : mem[word_idx];
        end
      end else begin
        data_ok_reg <= retire;
        if (retire) begin
          rdata_reg <= q_rdata[head_reg];
        end
      end
    end
  end

  // Queue payload needs no reset: an entry is only read after it was enqueued.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (q_age[i] != AGE_MAX) begin
        q_age[i] <= q_age[i] + 3'd1;
      end
    end
    if (enq) begin
      q_age[tail_reg]   <= AGE_START;
      q_rdata[tail_reg] <= inst_sram_wr ? 32'd0 : mem[word_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && inst_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (inst_sram_wstrb[b]) begin
          mem[word_idx][8*b +: 8] <= inst_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  assign inst_sram_data_ok = data_ok_reg;
  assign inst_sram_rdata   = rdata_reg;

endmodule

// File: tb/tb_inst_sram_like_slave.sv
// Directed bench: a LATENCY=1 instance driven from a vector table and a
// LATENCY=3 instance exercised with hand-written throughput and reset sequences.
module tb_inst_sram_like_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        resetn1, req1, wr1, addr_ok1, data_ok1;
  logic [1:0]  size1;
  logic [3:0]  wstrb1;
  logic [31:0] addr1, wdata1, rdata1;

  logic        resetn3, req3, wr3, addr_ok3, data_ok3;
  logic [1:0]  size3;
  logic [3:0]  wstrb3;
  logic [31:0] addr3, wdata3, rdata3;

  inst_sram_like_slave #(.ADDR_W(12), .LATENCY(1), .QDEPTH(2), .INIT_FILE("")) dut1 (
    .clk(clk), .resetn(resetn1), .inst_sram_req(req1), .inst_sram_wr(wr1),
    .inst_sram_size(size1), .inst_sram_wstrb(wstrb1), .inst_sram_addr(addr1),
    .inst_sram_wdata(wdata1), .inst_sram_addr_ok(addr_ok1),
    .inst_sram_data_ok(data_ok1), .inst_sram_rdata(rdata1)
  );

  inst_sram_like_slave #(.ADDR_W(12), .LATENCY(3), .QDEPTH(2), .INIT_FILE("")) dut3 (
    .clk(clk), .resetn(resetn3), .inst_sram_req(req3), .inst_sram_wr(wr3),
    .inst_sram_size(size3), .inst_sram_wstrb(wstrb3), .inst_sram_addr(addr3),
    .inst_sram_wdata(wdata3), .inst_sram_addr_ok(addr_ok3),
    .inst_sram_data_ok(data_ok3), .inst_sram_rdata(rdata3)
  );

  typedef struct {
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_ok;
    logic        exp_dok;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  logic [31:0] bench_mem [16];
  logic [31:0] exp_q [$];
  int          cyc_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request into dut3 and wait, bounded, for its address handshake.
  task automatic issue3(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    bit done;
    done   = 1'b0;
    req3   = 1'b1;
    wr3    = wr;
    addr3  = addr;
    wdata3 = wdata;
    wstrb3 = 4'hf;
    for (int t = 0; t < 10 && !done; t++) begin
      #1;
      if (addr_ok3) done = 1'b1;
      tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL issue3_timeout addr %h: got addr_ok 0 expected 1", addr);
    end
    req3 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] ok_pat;
    logic [11:0] dok_pat;
    int          next_w;
    logic [31:0] d;
    int          cy;

    // req, wr, wstrb, addr, wdata, exp_ok, exp_dok, exp_rdata (for the cycle the row is applied)
    vecs[0]  = '{1'b1, 1'b1, 4'hf, 32'h0000, 32'h3c080001, 1'b1, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b1, 1'b1, 4'hf, 32'h0010, 32'haabbccdd, 1'b1, 1'b1, 32'h00000000};
    vecs[2]  = '{1'b0, 1'b0, 4'h0, 32'h0000, 32'h00000000, 1'b1, 1'b1, 32'h00000000};
    vecs[3]  = '{1'b1, 1'b0, 4'h0, 32'h0000, 32'h00000000, 1'b1, 1'b0, 32'h00000000};
    vecs[4]  = '{1'b0, 1'b0, 4'h0, 32'h0000, 32'h00000000, 1'b1, 1'b1, 32'h3c080001};
    vecs[5]  = '{1'b0, 1'b0, 4'h0, 32'h0000, 32'h00000000, 1'b1, 1'b0, 32'h3c080001};
    vecs[6]  = '{1'b1, 1'b1, 4'hf, 32'h0004, 32'h24a50004, 1'b1, 1'b0, 32'h3c080001};
    vecs[7]  = '{1'b1, 1'b1, 4'hf, 32'h0008, 32'h8c030008, 1'b1, 1'b1, 32'h00000000};
    vecs[8]  = '{1'b1, 1'b0, 4'h0, 32'h0000, 32'h00000000, 1'b1, 1'b1, 32'h00000000};
    vecs[9]  = '{1'b1, 1'b0, 4'h0, 32'h0004, 32'h00000000, 1'b1, 1'b1, 32'h3c080001};
    vecs[10] = '{1'b1, 1'b0, 4'h0, 32'h0008, 32'h00000000, 1'b1, 1'b1, 32'h24a50004};
    vecs[11] = '{1'b0, 1'b0, 4'h0, 32'h0000, 32'h00000000, 1'b1, 1'b1, 32'h8c030008};
    vecs[12] = '{1'b0, 1'b0, 4'h0, 32'h0000, 32'h00000000, 1'b1, 1'b0, 32'h8c030008};
    vecs[13] = '{1'b1, 1'b1, 4'h5, 32'h0010, 32'h11223344, 1'b1, 1'b0, 32'h8c030008};
    vecs[14] = '{1'b1, 1'b0, 4'h0, 32'h0010, 32'h00000000, 1'b1, 1'b1, 32'h00000000};
    vecs[15] = '{1'b0, 1'b0, 4'h0, 32'h0000, 32'h00000000, 1'b1, 1'b1, 32'haa22cc44};
    vecs[16] = '{1'b0, 1'b0, 4'h0, 32'h0000, 32'h00000000, 1'b1, 1'b0, 32'haa22cc44};
    vecs[17] = '{1'b1, 1'b0, 4'h0, 32'h4000, 32'h00000000, 1'b1, 1'b0, 32'haa22cc44};
    vecs[18] = '{1'b1, 1'b0, 4'h0, 32'h0013, 32'h00000000, 1'b1, 1'b1, 32'h3c080001};
    vecs[19] = '{1'b0, 1'b0, 4'h0, 32'h0000, 32'h00000000, 1'b1, 1'b1, 32'haa22cc44};

    resetn1 = 1'b0; req1 = 1'b1; wr1 = 1'b0; size1 = 2'd2; wstrb1 = 4'h0; addr1 = 32'd0; wdata1 = 32'd0;
    resetn3 = 1'b0; req3 = 1'b1; wr3 = 1'b0; size3 = 2'd2; wstrb3 = 4'h0; addr3 = 32'd0; wdata3 = 32'd0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst%0d_addr_ok1", i), {31'd0, addr_ok1}, 32'd0);
      check($sformatf("rst%0d_data_ok1", i), {31'd0, data_ok1}, 32'd0);
      check($sformatf("rst%0d_rdata1", i), rdata1, 32'd0);
      check($sformatf("rst%0d_addr_ok3", i), {31'd0, addr_ok3}, 32'd0);
      check($sformatf("rst%0d_data_ok3", i), {31'd0, data_ok3}, 32'd0);
    end
    resetn1 = 1'b1;
    resetn3 = 1'b1;
    #1;
    check("rel0_addr_ok1", {31'd0, addr_ok1}, 32'd0);
    check("rel0_addr_ok3", {31'd0, addr_ok3}, 32'd0);
    tick();
    req1 = 1'b0;
    req3 = 1'b0;
    #1;
    check("rel1_addr_ok1", {31'd0, addr_ok1}, 32'd1);
    check("rel1_data_ok1", {31'd0, data_ok1}, 32'd0);
    check("rel1_addr_ok3", {31'd0, addr_ok3}, 32'd1);
    tick();

    // Latency-1 table
    for (int i = 0; i < NV; i++) begin
      check($sformatf("vec%0d_data_ok", i), {31'd0, data_ok1}, {31'd0, vecs[i].exp_dok});
      check($sformatf("vec%0d_rdata", i), rdata1, vecs[i].exp_rdata);
      req1   = vecs[i].req;
      wr1    = vecs[i].wr;
      wstrb1 = vecs[i].wstrb;
      addr1  = vecs[i].addr;
      wdata1 = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_addr_ok", i), {31'd0, addr_ok1}, {31'd0, vecs[i].exp_ok});
      tick();
    end
    req1 = 1'b0;

    // Latency-3: preload words 0..5, then drain
    for (int w = 0; w < 6; w++) begin
      bench_mem[w] = 32'hc0de0000 | (32'(w) * 32'h111);
      issue3(1'b1, 32'(w) * 32'd4, bench_mem[w]);
    end
    repeat (6) tick();

    // Latency-3 throughput with req held high for 9 cycles
    ok_pat  = 12'hEDB;
    dok_pat = 12'h6D8;
    next_w  = 0;
    for (int c = 0; c < 12; c++) begin
      check($sformatf("thr%0d_data_ok", c), {31'd0, data_ok3}, {31'd0, dok_pat[c]});
      if (data_ok3) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL thr%0d_extra_response: got data_ok 1 expected no response", c);
        end else begin
          d  = exp_q.pop_front();
          cy = cyc_q.pop_front();
          check($sformatf("thr%0d_rdata", c), rdata3, d);
          check($sformatf("thr%0d_latency", c), 32'(c - cy), 32'd3);
        end
      end
      req3 = (c < 9);
      wr3  = 1'b0;
      addr3 = 32'(next_w) * 32'd4;
      #1;
      check($sformatf("thr%0d_addr_ok", c), {31'd0, addr_ok3}, {31'd0, ok_pat[c]});
      if (req3 && addr_ok3) begin
        exp_q.push_back(bench_mem[next_w]);
        cyc_q.push_back(c);
        next_w++;
      end
      tick();
    end
    req3 = 1'b0;
    check("thr_pending_left", 32'(exp_q.size()), 32'd0);

    // Latency-3: two reads in flight, then reset; they must never respond
    req3 = 1'b1; addr3 = 32'd8;
    #1;
    check("rmid0_addr_ok", {31'd0, addr_ok3}, 32'd1);
    tick();
    addr3 = 32'd12;
    #1;
    check("rmid1_addr_ok", {31'd0, addr_ok3}, 32'd1);
    tick();
    req3 = 1'b0; resetn3 = 1'b0;
    #1;
    check("rmid2_addr_ok", {31'd0, addr_ok3}, 32'd0);
    tick();
    resetn3 = 1'b1;
    check("rmid3_rdata", rdata3, 32'd0);
    for (int c = 3; c < 9; c++) begin
      check($sformatf("rmid%0d_data_ok", c), {31'd0, data_ok3}, {31'd0, (c == 7)});
      if (c == 7) check("rmid7_rdata", rdata3, bench_mem[5]);
      req3  = (c == 4);
      addr3 = 32'd20;
      #1;
      if (c == 3) check("rmid3_addr_ok", {31'd0, addr_ok3}, 32'd0);
      if (c == 4) check("rmid4_addr_ok", {31'd0, addr_ok3}, 32'd1);
      tick();
    end
    req3 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
